// File: rtl/btn_debounce_pulse.sv
// Per-button synchronizer, debounce FSM and single-pulse generator for the raw push-buttons.
// Define BTN_DEBOUNCE_MCEN_EN to enable the auto-repeat output btn_mcen; otherwise it is tied to 0.
module btn_debounce_pulse #(
   parameter int N_BTN         = 5,
   parameter int DB_CYCLES     = 500000,
   parameter int CNT_W         = 20,
   parameter int REPEAT_CYCLES = 12500000,
   parameter int RPT_W         = 24
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_scen,
   output logic [N_BTN-1:0] btn_mcen
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WQ_PRESS = 3'd1;
   localparam logic [2:0] SCEN     = 3'd2;
   localparam logic [2:0] HELD     = 3'd3;
   localparam logic [2:0] WQ_REL   = 3'd4;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   // Out-of-range counts would never match the terminal compare and lock a lane up.
   if (DB_CYCLES < 1 || longint'(DB_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_db_cycles
      $error("DB_CYCLES out of range for CNT_W");
   end
   if (REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) > (longint'(1) << RPT_W) - 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range for RPT_W");
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_lane
      logic             sync_1;
      logic             btn_s;
      logic [2:0]       state;
      logic [CNT_W-1:0] cnt;

      // NOTE: every register here uses non-blocking assignments so all lanes and
      // both synchronizer stages update from the same pre-edge values.
      always_ff @(posedge Clk or posedge reset) begin
         if (reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
         end else begin
            sync_1 <= btn_in[g];
            btn_s  <= sync_1;
            case (state)
               IDLE: begin
                  if (btn_s) begin
                     state <= WQ_PRESS;
                     cnt   <= '0;
                  end
               end
               WQ_PRESS: begin
                  if (!btn_s)              state <= IDLE;
                  else if (cnt == DB_LAST) state <= SCEN;
                  else                     cnt   <= cnt + CNT_W'(1);
               end
               SCEN: state <= HELD;
               HELD: begin
                  if (!btn_s) begin
                     state <= WQ_REL;
                     cnt   <= '0;
                  end
               end
               WQ_REL: begin
                  if (btn_s)               state <= HELD;
                  else if (cnt == DB_LAST) state <= IDLE;
                  else                     cnt   <= cnt + CNT_W'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign btn_db[g]   = (state == SCEN) || (state == HELD) || (state == WQ_REL);
      assign btn_scen[g] = (state == SCEN);

`ifdef BTN_DEBOUNCE_MCEN_EN
      localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

      logic [RPT_W-1:0] rpt;
      logic             rpt_pulse;

      // The repeat phase restarts on every entry to HELD, including a bounce back from WQ_REL.
      always_ff @(posedge Clk or posedge reset) begin
         if (reset) begin
            rpt       <= '0;
            rpt_pulse <= 1'b0;
         end else if (state == SCEN || (state == WQ_REL && btn_s)) begin
            rpt       <= '0;
            rpt_pulse <= 1'b0;
         end else if (state == HELD && btn_s) begin
            if (rpt == RPT_LAST) begin
               rpt       <= '0;
               rpt_pulse <= 1'b1;
            end else begin
               rpt       <= rpt + RPT_W'(1);
               rpt_pulse <= 1'b0;
            end
         end else begin
            rpt_pulse <= 1'b0;
         end
      end

      assign btn_mcen[g] = (state == SCEN) | rpt_pulse;
`else
      assign btn_mcen[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: a sample-stability model predicts every cycle's outputs.
// Define BTN_DEBOUNCE_MCEN_EN here as well to check the auto-repeat output.
module tb_btn_debounce_pulse;

   localparam int N   = 5;
   localparam int DB  = 8;
   localparam int REP = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_db, btn_scen, btn_mcen;

   btn_debounce_pulse #(
      .N_BTN(N), .DB_CYCLES(DB), .CNT_W(20), .REPEAT_CYCLES(REP), .RPT_W(24)
   ) dut (
      .Clk(clk), .reset(reset), .btn_in(btn_in),
      .btn_db(btn_db), .btn_scen(btn_scen), .btn_mcen(btn_mcen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] db;
      logic [N-1:0] scen;
      logic [N-1:0] mcen;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_no = 0;
   int   scen_cnt[N];
   int   scen_edge[N];
   int   mcen_edges[$];

   // Reference model: a lane's level flips once the synchronized sample has disagreed
   // with it for DB+1 consecutive edges; the edge after an accepted press ignores the input.
   logic p1[N], p2[N], mdb[N], blind[N];
   int   run[N], hold[N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_no, act, exp);
      end
   endtask

   task automatic model_edge(input logic rst, output exp_t e);
      logic s, sc, rp;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            p1[i] = 0; p2[i] = 0; mdb[i] = 0; blind[i] = 0; run[i] = 0; hold[i] = 0;
         end else begin
            s = p2[i]; p2[i] = p1[i]; p1[i] = btn_in[i];
            sc = 0; rp = 0;
            if (blind[i]) begin
               blind[i] = 0; run[i] = 0; hold[i] = 0;
            end else if (s != mdb[i]) begin
               run[i]++;
               if (run[i] == DB + 1) begin
                  mdb[i] = s; run[i] = 0;
                  if (s) begin sc = 1; blind[i] = 1; end
               end
            end else begin
               if (mdb[i] && run[i] == 0) begin
                  hold[i]++;
                  if (hold[i] % REP == 0) rp = 1;
               end else begin
                  hold[i] = 0;
               end
               run[i] = 0;
            end
            e.db[i]   = mdb[i];
            e.scen[i] = sc;
`ifdef BTN_DEBOUNCE_MCEN_EN
            e.mcen[i] = sc | rp;
`endif
         end
      end
   endtask

   task automatic step(input logic [N-1:0] b, input logic r);
      exp_t e;
      @(negedge clk);
      btn_in = b;
      reset  = r;
      @(posedge clk);
      edge_no++;
      model_edge(r, e);
      exp_q.push_back(e);
   endtask

   task automatic hold_for(input int n, input logic [N-1:0] b);
      for (int k = 0; k < n; k++) step(b, 1'b0);
   endtask

   task automatic new_phase();
      edge_no = 0;
      mcen_edges.delete();
      for (int i = 0; i < N; i++) begin
         scen_cnt[i]  = 0;
         scen_edge[i] = -1;
      end
   endtask

   // Monitor: compares the DUT against each predicted cycle, away from the clock edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("btn_db",   32'(btn_db),   32'(e.db));
            check("btn_scen", 32'(btn_scen), 32'(e.scen));
            check("btn_mcen", 32'(btn_mcen), 32'(e.mcen));
            for (int i = 0; i < N; i++)
               if (btn_scen[i]) begin
                  scen_cnt[i]++;
                  scen_edge[i] = edge_no;
               end
            if (btn_mcen[0]) mcen_edges.push_back(edge_no);
         end
      end
   end

   initial begin : stimulus
      logic [N-1:0] lvl;
      int           left[N];
      int           rst_left;
      int           want_mcen[4];
      want_mcen = '{11, 28, 44, 60};
      new_phase();

      // Reset with all buttons held, then release reset while they are still held.
      for (int k = 0; k < 4; k++) step(5'h1f, 1'b1);
      new_phase();
      hold_for(20, 5'h1f);
      for (int i = 0; i < N; i++) begin
         check("reset_held_pulse_count", 32'(scen_cnt[i]), 32'd1);
         check("reset_held_pulse_edge",  32'(scen_edge[i]), 32'd11);
      end
      hold_for(20, 5'h00);

      // Clean press and release on lane 4.
      new_phase();
      hold_for(40, 5'b10000);
      check("clean_pulse_edge", 32'(scen_edge[4]), 32'd11);
      hold_for(20, 5'h00);
      check("clean_pulse_count", 32'(scen_cnt[4]), 32'd1);

      // Short glitch on every lane is rejected.
      new_phase();
      hold_for(5, 5'h1f);
      hold_for(20, 5'h00);
      check("glitch_pulses", 32'(scen_cnt[0] + scen_cnt[1] + scen_cnt[2] + scen_cnt[3] + scen_cnt[4]), 32'd0);

      // Press bounce then steady press on lane 3, then release bounce.
      new_phase();
      for (int k = 0; k < 12; k++) step(((k / 3) % 2 == 0) ? 5'b01000 : 5'b00000, 1'b0);
      hold_for(30, 5'b01000);
      check("bounce_pulse_edge", 32'(scen_edge[3]), 32'd23);
      for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 5'b00000 : 5'b01000, 1'b0);
      hold_for(10, 5'b01000);
      check("bounce_db_held", 32'(btn_db[3]), 32'd1);
      hold_for(20, 5'h00);
      check("bounce_pulse_count", 32'(scen_cnt[3]), 32'd1);

      // Simultaneous lanes 0 and 2, lane 1 three cycles later.
      new_phase();
      hold_for(3, 5'b00101);
      hold_for(30, 5'b00111);
      check("simul_lane0_edge", 32'(scen_edge[0]), 32'd11);
      check("simul_lane2_edge", 32'(scen_edge[2]), 32'd11);
      check("simul_lane1_edge", 32'(scen_edge[1]), 32'd14);
      hold_for(20, 5'h00);

      // Long hold on lane 0 for auto-repeat.
      new_phase();
      hold_for(70, 5'b00001);
      check("mcen_scen_count", 32'(scen_cnt[0]), 32'd1);
`ifdef BTN_DEBOUNCE_MCEN_EN
      check("mcen_pulse_count", 32'(mcen_edges.size()), 32'd4);
      for (int k = 0; k < 4 && k < mcen_edges.size(); k++)
         check("mcen_pulse_edge", 32'(mcen_edges[k]), 32'(want_mcen[k]));
`else
      check("mcen_pulse_count", 32'(mcen_edges.size()), 32'd0);
`endif
      hold_for(20, 5'h00);

      // Reset while lane 2 is held: the lane re-debounces and pulses again.
      new_phase();
      hold_for(20, 5'b00100);
      step(5'b00100, 1'b1);
      step(5'b00100, 1'b1);
      hold_for(20, 5'b00100);
      check("midreset_pulse_count", 32'(scen_cnt[2]), 32'd2);
      hold_for(20, 5'h00);

      // Randomized bouncing levels with occasional resets.
      lvl = '0;
      rst_left = 0;
      for (int i = 0; i < N; i++) left[i] = $urandom_range(1, 14);
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            left[i]--;
            if (left[i] <= 0) begin
               lvl[i]  = ~lvl[i];
               left[i] = $urandom_range(1, 14);
            end
         end
         if (rst_left > 0) rst_left--;
         else if ($urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 2);
         step(lvl, rst_left > 0);
      end
      hold_for(4, 5'h00);

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
